// File: rtl/mac_lane_array.sv
// mac_lane_array: six-lane signed multiply-accumulate with tap counting and valid/ready result handshake.
module mac_lane_array #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               MAC_layer,
  input  logic                     start,
  input  logic [CNT_W-1:0]         tap_count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pixel_0,
  input  logic signed [DATA_W-1:0] pixel_1,
  input  logic signed [DATA_W-1:0] pixel_2,
  input  logic signed [DATA_W-1:0] pixel_3,
  input  logic signed [DATA_W-1:0] pixel_4,
  input  logic signed [DATA_W-1:0] pixel_5,
  input  logic signed [DATA_W-1:0] weight_0,
  input  logic signed [DATA_W-1:0] weight_1,
  input  logic signed [DATA_W-1:0] weight_2,
  input  logic signed [DATA_W-1:0] weight_3,
  input  logic signed [DATA_W-1:0] weight_4,
  input  logic signed [DATA_W-1:0] weight_5,
  output logic signed [ACC_W-1:0]  MAC_out_0,
  output logic signed [ACC_W-1:0]  MAC_out_1,
  output logic signed [ACC_W-1:0]  MAC_out_2,
  output logic signed [ACC_W-1:0]  MAC_out_3,
  output logic signed [ACC_W-1:0]  MAC_out_4,
  output logic signed [ACC_W-1:0]  MAC_out_5,
  output logic [1:0]               MAC_layer_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic signed [DATA_W-1:0] px [6];
  logic signed [DATA_W-1:0] wt [6];
  logic signed [ACC_W-1:0]  prod_q [6];
  logic signed [ACC_W-1:0]  acc_q [6];
  logic [CNT_W-1:0]         cnt_q, tap_q;
  logic [1:0]               layer_q;
  logic                     pflag_q, start_ok, accept, last_beat;
  assign px = '{pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5};
  assign wt = '{weight_0, weight_1, weight_2, weight_3, weight_4, weight_5};
  assign start_ok  = (state_q == IDLE) && start && (MAC_layer != 2'b11);
  assign accept    = (state_q == ACC) && in_valid;
  assign last_beat = (cnt_q + CNT_W'(1)) == tap_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ok ? ((tap_count == '0) ? DONE : ACC) : IDLE;
      ACC:     state_d = (accept && last_beat) ? DRAIN : ACC;
      DRAIN:   state_d = DONE;
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == ACC;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  // Products are registered one beat ahead; the flag tells the accumulators to add them next cycle.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      layer_q <= '0;
      tap_q   <= '0;
      cnt_q   <= '0;
      pflag_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else if (start_ok) begin
      layer_q <= MAC_layer;
      tap_q   <= tap_count;
      cnt_q   <= '0;
      pflag_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      pflag_q <= accept;
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      for (int k = 0; k < 6; k++) begin
        if (accept) prod_q[k] <= $signed(ACC_W'(px[k])) * $signed(ACC_W'(wt[k]));
        if (pflag_q) acc_q[k] <= acc_q[k] + prod_q[k];
      end
    end
  assign MAC_out_0   = acc_q[0];
  assign MAC_out_1   = acc_q[1];
  assign MAC_out_2   = acc_q[2];
  assign MAC_out_3   = acc_q[3];
  assign MAC_out_4   = acc_q[4];
  assign MAC_out_5   = acc_q[5];
  assign MAC_layer_q = layer_q;
endmodule

// File: tb/tb_mac_lane_array.sv
// tb_mac_lane_array: randomized and directed jobs checked against a per-lane dot-product model.
module tb_mac_lane_array;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  logic [1:0] MAC_layer = 0;
  logic start = 0;
  logic [9:0] tap_count = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [1:0] MAC_layer_q;
  logic signed [15:0] pixel [6];
  logic signed [15:0] weight [6];
  logic signed [31:0] mo [6];
  logic signed [15:0] pv [1024][6];
  logic signed [15:0] wv [1024][6];
  int exp_sum [6];
  int n_chk = 0;
  int n_pass = 0;

  mac_lane_array dut (
    .clk(clk), .reset_n(reset_n), .MAC_layer(MAC_layer), .start(start), .tap_count(tap_count),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel_0(pixel[0]), .pixel_1(pixel[1]), .pixel_2(pixel[2]),
    .pixel_3(pixel[3]), .pixel_4(pixel[4]), .pixel_5(pixel[5]),
    .weight_0(weight[0]), .weight_1(weight[1]), .weight_2(weight[2]),
    .weight_3(weight[3]), .weight_4(weight[4]), .weight_5(weight[5]),
    .MAC_out_0(mo[0]), .MAC_out_1(mo[1]), .MAC_out_2(mo[2]),
    .MAC_out_3(mo[3]), .MAC_out_4(mo[4]), .MAC_out_5(mo[5]),
    .MAC_layer_q(MAC_layer_q), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill(input int taps, input bit rnd, input int p, input int w);
    for (int i = 0; i < taps; i++)
      for (int k = 0; k < 6; k++) begin
        pv[i][k] = rnd ? 16'($urandom) : 16'(p);
        wv[i][k] = rnd ? 16'($urandom) : 16'(w);
      end
  endtask

  // bub: 0 none, 1 alternating 1,0,1,0..., 2 random
  task automatic run_job(input logic [1:0] layer, input int taps, input int bub, input int hold, input bit poke);
    int beats, cyc;
    logic v;
    for (int k = 0; k < 6; k++) begin
      exp_sum[k] = 0;
      for (int i = 0; i < taps; i++) exp_sum[k] += int'(pv[i][k]) * int'(wv[i][k]);
    end
    @(negedge clk);
    start = 1; MAC_layer = layer; tap_count = 10'(taps); in_valid = 0;
    @(negedge clk);
    start = 0; cyc = 1;
    check("busy_up", 32'(busy), 1);
    if (taps == 0) check("zero_ovalid", 32'(out_valid), 1);
    else check("in_ready_up", 32'(in_ready), 1);
    beats = 0;
    while (beats < taps && cyc < 4000) begin
      v = (bub == 0) ? 1'b1 : (bub == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
      in_valid = v;
      for (int k = 0; k < 6; k++) begin
        pixel[k]  = v ? pv[beats][k] : 16'($urandom);
        weight[k] = v ? wv[beats][k] : 16'($urandom);
      end
      start = poke && beats == 1;
      MAC_layer = poke ? 2'b00 : layer;
      tap_count = poke ? 10'd1 : 10'(taps);
      @(negedge clk);
      cyc++;
      if (v) beats++;
    end
    start = 0;
    check("beats_done", 32'(beats), 32'(taps));
    if (taps > 0) begin
      check("in_ready_drain", 32'(in_ready), 0);
      check("ovalid_drain", 32'(out_valid), 0);
      in_valid = 1;
      for (int k = 0; k < 6; k++) begin pixel[k] = 16'h7fff; weight[k] = 16'h7fff; end
      @(negedge clk);
      cyc++;
      in_valid = 0;
      if (bub == 0) check("latency", 32'(cyc), 32'(taps + 2));
    end
    check("ovalid", 32'(out_valid), 1);
    check("layer_q", 32'(MAC_layer_q), 32'(layer));
    for (int k = 0; k < 6; k++) check($sformatf("mac_out_%0d", k), mo[k], exp_sum[k]);
    for (int h = 0; h < hold; h++) begin
      start = poke;
      @(negedge clk);
      start = 0;
      check("ovalid_hold", 32'(out_valid), 1);
      check("hold_stable", mo[h % 6], exp_sum[h % 6]);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("ovalid_drop", 32'(out_valid), 0);
    check("busy_drop", 32'(busy), 0);
    check("sums_kept", mo[5], exp_sum[5]);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin pixel[k] = 0; weight[k] = 0; end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ovalid", 32'(out_valid), 0);
    check("rst_out0", mo[0], 0);
    check("rst_layer", 32'(MAC_layer_q), 0);
    reset_n = 1;
    for (int i = 0; i < 25; i++) for (int k = 0; k < 6; k++) begin pv[i][k] = 2; wv[i][k] = 16'(k + 1); end
    run_job(2'b00, 25, 0, 0, 0);
    check("conv1_lane5", mo[5], 300);
    fill(4, 0, -3, 7);
    run_job(2'b10, 4, 1, 5, 1);
    check("fc_sum", mo[2], -84);
    fill(3, 0, -32768, -32768);
    run_job(2'b01, 3, 0, 1, 0);
    check("wrap_sum", mo[0], 32'hc000_0000);
    run_job(2'b10, 0, 0, 2, 0);
    check("zero_sum", mo[3], 0);
    @(negedge clk);
    start = 1; MAC_layer = 2'b11; tap_count = 5;
    @(negedge clk);
    start = 0;
    check("illegal_busy", 32'(busy), 0);
    check("illegal_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("illegal_idle", 32'(busy), 0);
    start = 1; MAC_layer = 2'b01; tap_count = 10;
    @(negedge clk);
    start = 0; in_valid = 1;
    for (int k = 0; k < 6; k++) begin pixel[k] = 5; weight[k] = 5; end
    repeat (3) @(negedge clk);
    check("pre_rst_acc", mo[1], 50);
    reset_n = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_ovalid", 32'(out_valid), 0);
    check("mid_rst_out1", mo[1], 0);
    check("mid_rst_layer", 32'(MAC_layer_q), 0);
    @(negedge clk);
    in_valid = 0; reset_n = 1;
    fill(7, 1, 0, 0);
    run_job(2'b01, 7, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      int taps;
      taps = $urandom_range(1, 40);
      fill(taps, 1, 0, 0);
      run_job(2'($urandom_range(0, 2)), taps, 2, $urandom_range(0, 3), j[0]);
    end
    fill(1, 1, 0, 0);
    run_job(2'b00, 1, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_lane_array.md
# mac_lane_array

Six-lane signed multiply-accumulate engine that sits directly upstream of the post-MAC bias/ReLU/shift stage and produces its `MAC_out_0..5` operands. The array serves three layer types:

- conv1: six filters over one image.
- conv2: six input channels into one filter.
- Fully connected: six neurons.

Each lane accumulates a controller-specified number of pixel×weight taps, then presents the 32-bit sums with a valid/ready handshake.

## Interface

Parameters:

- `DATA_W`, default 16: signed pixel/weight width.
- `ACC_W`, default 32: signed product/accumulator width. Must equal 2×`DATA_W`.
- `CNT_W`, default 10: tap-counter width. Maximum 1023 taps per job.

Ports:

- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `MAC_layer`, in, 2: layer code (00 conv1, 01 conv2, 10 FC, 11 illegal). Sampled on an accepted `start`.
- `start`, in, 1: job request. Accepted only in IDLE.
- `tap_count`, in, `CNT_W`: number of taps in the job. Sampled on an accepted `start`.
- `in_valid`, in, 1: tap beat valid.
- `in_ready`, out, 1: array accepts a tap beat.
- `pixel_0..pixel_5`, in, `DATA_W` signed each: per-lane pixel operand.
- `weight_0..weight_5`, in, `DATA_W` signed each: per-lane weight operand.
- `MAC_out_0..MAC_out_5`, out, `ACC_W` signed each: lane accumulators.
- `MAC_layer_q`, out, 2: layer code latched for the current job; drives the post-MAC stage.
- `out_valid`, out, 1: sums complete and stable.
- `out_ready`, in, 1: downstream consumes the sums.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

States: IDLE, ACC, DRAIN, DONE.

- **IDLE**
  - `start`=1 with `MAC_layer`≠11: latch `MAC_layer` and `tap_count`, clear all accumulators and the product registers, reset the beat counter to 0.
    - Next state is ACC, or DONE if `tap_count`=0.
  - `start` with `MAC_layer`=11: ignored; stay in IDLE.
- **ACC**
  - `in_ready`=1.
  - Beat accepted when `in_valid`&`in_ready`.
  - Each accepted beat:
    - Product register k ← `pixel_k`×`weight_k` (full `ACC_W` signed product).
    - A pipeline flag marks the product valid.
    - Beat counter increments.
  - Each cycle with the product flag set: accumulator k ← accumulator k + product k.
  - On the accept that makes the counter equal `tap_count`: next state DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - The final product is added to the accumulators.
  - Next state DONE.
- **DONE**
  - `out_valid`=1; `MAC_out_*` held constant.
  - On `out_ready`=1: next state IDLE. Accumulators keep their values until the next `start`.
- `start` is ignored in ACC, DRAIN and DONE. It is not queued.
- Bubbles (`in_valid`=0 in ACC) insert no product and do not advance the counter.
- Arithmetic:
  - Signed two's complement throughout.
  - Accumulation wraps modulo 2^`ACC_W`; there is no saturation.
  - No bias, ReLU or shift is applied here; those belong to the downstream stage.

## Timing

- Reset (async assert, sync-released use) values:
  - State IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `MAC_out_0..5`=0.
  - `MAC_layer_q`=00.
  - Beat counter, product registers and product flag cleared.
- Reset mid-job: the job is abandoned with no output; state returns to IDLE.
- Start latency: `start` accepted in cycle S → `in_ready`=1 in cycle S+1.
- Result latency: final beat accepted in cycle T → DRAIN in T+1 → `out_valid`=1 from cycle T+2.
  - Minimum job with N taps and no bubbles: `start` at S → `out_valid` at S+N+2.
- `tap_count`=0: `start` at S → `out_valid`=1 at S+1 with all sums 0.
- `in_ready` falls in the cycle after the final accept. A beat presented then is not consumed.
- `out_valid` drops in the cycle after `out_ready` is sampled high. `busy` drops together with it.
- Earliest back-to-back job: `start` in the first IDLE cycle after the handshake.
- `MAC_out_*` and `MAC_layer_q` are registered outputs with no combinational input-to-output path.

## Test plan

- **Reset:** assert `reset_n`=0 mid-ACC → all outputs at reset values in the same cycle; after release, `start` works normally.
- **conv1 job:** `MAC_layer`=00, `tap_count`=25, all pixels 2, `weight_k`=k+1, no bubbles → `out_valid` at S+27 with `MAC_out_k`=50·(k+1). `MAC_layer_q`=00.
- **Bubbles and backpressure:** FC job (10), `tap_count`=4, `in_valid` toggling 1,0,1,0…, pixel −3, weight 7 → every `MAC_out`=−84.
  - Hold `out_ready`=0 for 5 cycles → outputs stable and `out_valid` held.
  - `out_ready`=1 → IDLE next cycle.
- **Wrap:** `tap_count`=3, pixel=weight=−32768 (product 2^30) → `MAC_out`=−1073741824 (3·2^30 mod 2^32).
- **Edge codes:** `tap_count`=0 → `out_valid` at S+1, sums 0. `start` with `MAC_layer`=11 → stays IDLE, `busy`=0.
- **Ignored start:** `start` pulsed during ACC and DONE → no restart, no clearing; the sums of the original job are unchanged.
